// File: rtl/gin_leak_scheduler.sv
// gin_leak_scheduler: sweeps every neuron's gin through the shared leak
// datapath once per timestep, one neuron per cycle, writing back in place.
module gin_leak_scheduler #(
  parameter int INTEGER_WIDTH   = 16,
  parameter int DATA_WIDTH_FRAC = 32,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int DELTAT_WIDTH    = 4,
  parameter int NEURON_WIDTH    = 11
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [NEURON_WIDTH:0]    NeuronCount,
  input  logic [DELTAT_WIDTH-1:0]  DeltaT,
  input  logic [INTEGER_WIDTH-1:0] Taugin,
  output logic                     Busy,
  output logic                     Done,
  output logic                     ParamError,
  output logic                     GinRdEn,
  output logic [NEURON_WIDTH-1:0]  GinRdAddr,
  input  logic [DATA_WIDTH-1:0]    GinRdData,
  output logic                     GinWrEn,
  output logic [NEURON_WIDTH-1:0]  GinWrAddr,
  output logic [DATA_WIDTH-1:0]    GinWrData,
  output logic [DATA_WIDTH-1:0]    LeakGin,
  output logic [DELTAT_WIDTH-1:0]  LeakDeltaT,
  output logic [INTEGER_WIDTH-1:0] LeakTaugin,
  input  logic [DATA_WIDTH-1:0]    LeakGinOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [NEURON_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [NEURON_WIDTH-1:0] ADDR_ONE = 1;

  state_t                  state_q;
  state_t                  state_d;
  logic [NEURON_WIDTH:0]   cnt_q;
  logic                    vb_q;
  logic [NEURON_WIDTH-1:0] ab_q;
  logic                    go;
  logic                    last;
  logic                    issue;

  // Next-state logic; a start with no work or a zero time constant
  // completes immediately without touching the RAM.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    last    = ({1'b0, GinRdAddr} == (cnt_q - CNT_ONE));
    issue   = (state_q == RUN) && !last;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          if ((NeuronCount != '0) && (Taugin != '0)) begin
            go      = 1'b1;
            state_d = RUN;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN:     if (last) state_d = DRAIN;
      DRAIN:   if (!vb_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Status flags, latched sweep parameters and read issue (stage A).
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Busy       <= 1'b0;
      Done       <= 1'b0;
      ParamError <= 1'b0;
      cnt_q      <= '0;
      LeakDeltaT <= '0;
      LeakTaugin <= '0;
      GinRdEn    <= 1'b0;
      GinRdAddr  <= '0;
    end else begin
      Busy    <= (state_d == RUN) || (state_d == DRAIN);
      Done    <= (state_d == DONE);
      GinRdEn <= go || issue;
      if ((state_q == IDLE) && Start) begin
        ParamError <= (Taugin == '0);
        cnt_q      <= NeuronCount;
        LeakDeltaT <= DeltaT;
        LeakTaugin <= Taugin;
      end
      if (go)         GinRdAddr <= '0;
      else if (issue) GinRdAddr <= GinRdAddr + ADDR_ONE;
    end
  end

  // Stage B valid/address, then stage C write-back of the leak result.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vb_q      <= 1'b0;
      ab_q      <= '0;
      GinWrEn   <= 1'b0;
      GinWrAddr <= '0;
      GinWrData <= '0;
    end else begin
      vb_q      <= GinRdEn;
      ab_q      <= GinRdAddr;
      GinWrEn   <= vb_q;
      GinWrAddr <= ab_q;
      if (vb_q) GinWrData <= LeakGinOut;
    end
  end

  assign LeakGin = vb_q ? GinRdData : '0;

endmodule

// File: tb/tb_gin_leak_scheduler.sv
// tb_gin_leak_scheduler: RAM + leak unit environment around the scheduler,
// with a cycle-indexed timing model and a post-sweep memory image check.
module tb_gin_leak_scheduler;

  localparam int DW = 48;
  localparam int NW = 11;
  localparam int NN = 2048;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic [NW:0]   NeuronCount;
  logic [3:0]    DeltaT;
  logic [15:0]   Taugin;
  logic          Busy;
  logic          Done;
  logic          ParamError;
  logic          GinRdEn;
  logic [NW-1:0] GinRdAddr;
  logic [DW-1:0] GinRdData;
  logic          GinWrEn;
  logic [NW-1:0] GinWrAddr;
  logic [DW-1:0] GinWrData;
  logic [DW-1:0] LeakGin;
  logic [3:0]    LeakDeltaT;
  logic [15:0]   LeakTaugin;
  logic [DW-1:0] LeakGinOut;

  logic [DW-1:0] mem   [NN];
  logic [DW-1:0] init  [NN];
  logic [DW-1:0] gold  [NN];
  logic          load;

  int total;
  int bad;

  gin_leak_scheduler dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .NeuronCount(NeuronCount), .DeltaT(DeltaT), .Taugin(Taugin),
    .Busy(Busy), .Done(Done), .ParamError(ParamError),
    .GinRdEn(GinRdEn), .GinRdAddr(GinRdAddr), .GinRdData(GinRdData),
    .GinWrEn(GinWrEn), .GinWrAddr(GinWrAddr), .GinWrData(GinWrData),
    .LeakGin(LeakGin), .LeakDeltaT(LeakDeltaT), .LeakTaugin(LeakTaugin),
    .LeakGinOut(LeakGinOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // gin - gin*(dt/16)/tau in signed fixed point
  function automatic logic [DW-1:0] leak_f(input logic [DW-1:0] g,
                                           input logic [3:0] dt,
                                           input logic [15:0] tau);
    logic signed [95:0] gs;
    logic signed [95:0] d;
    if (tau == 16'd0) return g;
    gs = $signed({{48{g[DW-1]}}, g});
    d  = (gs * $signed({92'd0, dt})) >>> 4;
    d  = d / $signed({80'd0, tau});
    return g - d[DW-1:0];
  endfunction

  assign LeakGinOut = leak_f(LeakGin, LeakDeltaT, LeakTaugin);

  // synchronous-read RAM with a bench-side bulk load
  always @(posedge Clock) begin
    if (load) begin
      mem <= init;
    end else begin
      if (GinRdEn) GinRdData <= mem[GinRdAddr];
      if (GinWrEn) mem[GinWrAddr] <= GinWrData;
    end
  end

  task automatic sweep(input int n, input logic [3:0] dt,
                       input logic [15:0] tau, input bit disturb,
                       input int rst_cyc);
    bit   degen;
    int   last_c;
    bit   e_busy, e_done, e_rd, e_wr, e_perr;
    int   nbad;
    int   first_bad;
    gold = init;
    @(negedge Clock);
    load = 1'b1;
    @(negedge Clock);
    load        = 1'b0;
    Start       = 1'b1;
    NeuronCount = 12'(n);
    DeltaT      = dt;
    Taugin      = tau;
    degen  = (n == 0) || (tau == 16'd0);
    last_c = degen ? 2 : n + 4;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge Clock);
      if (c == 1) Start = 1'b0;
      if (disturb && c == 2) begin
        Start       = 1'b1;
        DeltaT      = 4'($urandom);
        Taugin      = 16'($urandom);
        NeuronCount = 12'($urandom);
      end
      if (disturb && c == 3) Start = 1'b0;
      if (degen) begin
        e_busy = 1'b0;
        e_done = (c == 1);
        e_rd   = 1'b0;
        e_wr   = 1'b0;
        e_perr = (tau == 16'd0);
      end else begin
        e_busy = (c <= n + 2);
        e_done = (c == n + 3);
        e_rd   = (c <= n);
        e_wr   = (c >= 3) && (c <= n + 2);
        e_perr = 1'b0;
      end
      total++;
      assert ({Busy, Done, GinRdEn, GinWrEn, ParamError} ===
              {e_busy, e_done, e_rd, e_wr, e_perr})
      else begin
        bad++;
        $error("FAIL ctl n=%0d c=%0d got=%b exp=%b", n, c,
               {Busy, Done, GinRdEn, GinWrEn, ParamError},
               {e_busy, e_done, e_rd, e_wr, e_perr});
      end
      total++;
      assert ({LeakDeltaT, LeakTaugin} === {dt, tau})
      else begin
        bad++;
        $error("FAIL leakparams c=%0d got=%h/%h exp=%h/%h", c,
               LeakDeltaT, LeakTaugin, dt, tau);
      end
      if (e_rd) begin
        total++;
        assert (GinRdAddr === 11'(c - 1))
        else begin
          bad++;
          $error("FAIL rdaddr c=%0d got=%0d exp=%0d", c, GinRdAddr, c - 1);
        end
      end
      if (e_wr) begin
        total++;
        assert ({GinWrAddr, GinWrData} ===
                {11'(c - 3), leak_f(gold[c - 3], dt, tau)})
        else begin
          bad++;
          $error("FAIL write c=%0d got=%0d:%h exp=%0d:%h", c, GinWrAddr,
                 GinWrData, c - 3, leak_f(gold[c - 3], dt, tau));
        end
      end
      if (c == rst_cyc) begin
        Reset = 1'b0;
        #1;
        total++;
        assert ({Busy, Done, ParamError, GinRdEn, GinWrEn, GinRdAddr,
                 GinWrAddr, GinWrData, LeakGin, LeakDeltaT,
                 LeakTaugin} === '0)
        else begin
          bad++;
          $error("FAIL reset_outputs got busy=%b done=%b rd=%b wr=%b wd=%h exp all 0",
                 Busy, Done, GinRdEn, GinWrEn, GinWrData);
        end
        return;
      end
    end
    nbad = 0;
    first_bad = -1;
    for (int i = 0; i < NN; i++) begin
      logic [DW-1:0] e;
      e = (i < n && !degen) ? leak_f(gold[i], dt, tau) : gold[i];
      if (mem[i] !== e) begin
        nbad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total++;
    assert (nbad === 0)
    else begin
      bad++;
      $error("FAIL memimage n=%0d got %0d bad words (first %0d) exp 0",
             n, nbad, first_bad);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < NN; i++) init[i] = 48'({$urandom, $urandom});
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    load        = 1'b0;
    Start       = 1'b0;
    NeuronCount = '0;
    DeltaT      = '0;
    Taugin      = '0;
    Reset       = 1'b0;
    fill_random();
    repeat (2) @(negedge Clock);
    total++;
    assert ({Busy, Done, ParamError, GinRdEn, GinWrEn, GinRdAddr,
             GinWrAddr, GinWrData, LeakGin, LeakDeltaT, LeakTaugin} === '0)
    else begin
      bad++;
      $error("FAIL por got busy=%b done=%b perr=%b exp all 0",
             Busy, Done, ParamError);
    end
    Reset = 1'b1;

    // N=4, all gin = 1.0
    fill_random();
    for (int i = 0; i < 4; i++) init[i] = 48'h0001_0000_0000;
    sweep(4, 4'd8, 16'd2, 1'b0, 0);
    total++;
    assert (mem[3] === 48'h0000_C000_0000)
    else begin
      bad++;
      $error("FAIL onepoint got=%h exp=%h", mem[3], 48'h0000_C000_0000);
    end

    // full range, mixed gin including -1.0
    fill_random();
    init[0] = 48'h0001_0000_0000;
    init[5] = 48'hFFFF_0000_0000;
    sweep(NN, 4'd8, 16'd2, 1'b0, 0);
    total++;
    assert (mem[5] === 48'hFFFF_4000_0000)
    else begin
      bad++;
      $error("FAIL neg1 got=%h exp=%h", mem[5], 48'hFFFF_4000_0000);
    end

    // degenerate starts, then a valid start clears ParamError
    fill_random();
    sweep(0, 4'd3, 16'd7, 1'b0, 0);
    sweep(5, 4'd3, 16'd0, 1'b0, 0);
    fill_random();
    sweep(6, 4'd5, 16'd3, 1'b0, 0);

    // Start and parameter changes mid-sweep are ignored
    fill_random();
    sweep(9, 4'd12, 16'd5, 1'b1, 0);
    fill_random();
    sweep(1, 4'd15, 16'd1, 1'b1, 0);

    // reset in cycle 4 of an N=10 sweep, then a clean N=3 sweep
    fill_random();
    sweep(10, 4'd8, 16'd2, 1'b0, 4);
    @(negedge Clock);
    Reset = 1'b1;
    fill_random();
    sweep(3, 4'd8, 16'd2, 1'b0, 0);

    // randomized sweeps
    for (int k = 0; k < 12; k++) begin
      int   n;
      logic [3:0]  dt;
      logic [15:0] tau;
      fill_random();
      n   = $urandom_range(1, 64);
      dt  = 4'($urandom);
      tau = 16'($urandom_range(1, 300));
      sweep(n, dt, tau, 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
